// File: rtl/prg_loader_if.sv
// Byte-receiver input and main-memory write port of the boot program loader.
interface prg_loader_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 12
);
    logic                  rx_valid;
    logic [7:0]            rx_byte;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_we;

    // Environment side: feeds bytes, observes memory writes
    modport master (
        output rx_valid, rx_byte,
        input  mem_addr, mem_data, mem_we
    );

    // Loader side
    modport slave (
        input  rx_valid, rx_byte,
        output mem_addr, mem_data, mem_we
    );
endinterface

// File: rtl/prg_loader.sv
// Boot-time program loader: parses SYNC,N,{HI,LO}*N,CHK frames from the UART,
// writes 12-bit words from address 0 and releases core_hold on a good checksum.
module prg_loader #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 12,
    parameter int unsigned MAX_WORDS      = 255,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         reset_n,
    prg_loader_if.slave  bus,
    output logic         core_hold,
    output logic         load_done,
    output logic         load_error
);

    localparam int unsigned CNT_W  = $clog2(MAX_WORDS + 1);
    localparam int unsigned CNT_W1 = CNT_W + 1;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        WAIT_SYNC,
        GET_N,
        GET_HI,
        GET_LO,
        WRITE,
        GET_CHK,
        DONE,
        ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            chk_q, chk_d;
    logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]      n_q, n_d;
    logic [3:0]            hi_q, hi_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  mem_we_q, mem_we_d;
    logic                  core_hold_q, core_hold_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;
    logic                  timer_active;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= WAIT_SYNC;
            chk_q        <= '0;
            word_cnt_q   <= '0;
            n_q          <= '0;
            hi_q         <= '0;
            timer_q      <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            core_hold_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            chk_q        <= chk_d;
            word_cnt_q   <= word_cnt_d;
            n_q          <= n_d;
            hi_q         <= hi_d;
            timer_q      <= timer_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            core_hold_q  <= core_hold_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    // Frame parser, inter-byte timer and next output values
    always_comb begin
        state_d    = state_q;
        chk_d      = chk_q;
        word_cnt_d = word_cnt_q;
        n_d        = n_q;
        hi_d       = hi_q;
        timer_d    = '0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        timer_active = state_q inside {GET_N, GET_HI, GET_LO, WRITE, GET_CHK};
        if (timer_active) begin
            timer_d = bus.rx_valid ? '0 : timer_q + TMR_W'(1);
        end

        unique case (state_q)
            WAIT_SYNC, DONE, ERROR: begin
                if (bus.rx_valid && bus.rx_byte == SYNC_BYTE) begin
                    state_d    = GET_N;
                    chk_d      = '0;
                    word_cnt_d = '0;
                end
            end
            GET_N: begin
                if (bus.rx_valid) begin
                    chk_d = chk_q ^ bus.rx_byte;
                    if (bus.rx_byte == 8'h00) begin
                        state_d = GET_CHK;
                    end else if (32'(bus.rx_byte) > MAX_WORDS) begin
                        state_d = ERROR;
                    end else begin
                        n_d     = CNT_W'(bus.rx_byte);
                        state_d = GET_HI;
                    end
                end
            end
            GET_HI: begin
                if (bus.rx_valid) begin
                    chk_d = chk_q ^ bus.rx_byte;
                    if (bus.rx_byte[7:4] != 4'h0) begin
                        state_d = ERROR;
                    end else begin
                        hi_d    = bus.rx_byte[3:0];
                        state_d = GET_LO;
                    end
                end
            end
            GET_LO: begin
                if (bus.rx_valid) begin
                    chk_d      = chk_q ^ bus.rx_byte;
                    mem_addr_d = ADDR_WIDTH'(word_cnt_q);
                    mem_data_d = DATA_WIDTH'({hi_q, bus.rx_byte});
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                // Bytes arriving here are dropped; upstream pacing rules them out
                word_cnt_d = word_cnt_q + CNT_W'(1);
                if (CNT_W1'(word_cnt_q) + CNT_W1'(1) == CNT_W1'(n_q)) begin
                    state_d = GET_CHK;
                end else begin
                    state_d = GET_HI;
                end
            end
            GET_CHK: begin
                if (bus.rx_valid) begin
                    state_d = (bus.rx_byte == chk_q) ? DONE : ERROR;
                end
            end
            default: state_d = WAIT_SYNC;
        endcase

        if (timer_active && state_q != WRITE && !bus.rx_valid &&
            timer_d == TMR_W'(TIMEOUT_CYCLES)) begin
            state_d = ERROR;
        end

        mem_we_d     = (state_d == WRITE);
        core_hold_d  = (state_d != DONE);
        load_done_d  = (state_d == DONE);
        load_error_d = (state_d == ERROR);
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.mem_we   = mem_we_q;
    assign core_hold    = core_hold_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;

endmodule

// File: tb/tb_prg_loader.sv
// Self-checking bench for prg_loader: directed frames plus random frames
// checked against a frame-level model of writes and final status.
module tb_prg_loader;

    localparam int unsigned TMO  = 50;
    localparam int unsigned MAXW = 20;

    logic clk = 1'b0;
    logic reset_n;
    logic core_hold, load_done, load_error;

    always #5 clk = ~clk;

    prg_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(12)) bus ();

    prg_loader #(
        .ADDR_WIDTH    (12),
        .DATA_WIDTH    (12),
        .MAX_WORDS     (MAXW),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .core_hold (core_hold),
        .load_done (load_done),
        .load_error(load_error)
    );

    typedef struct {
        logic [11:0] addr;
        logic [11:0] data;
    } wr_t;
    typedef logic [7:0] bq_t[$];

    int  n_cmp = 0;
    int  n_bad = 0;
    wr_t got_q[$];
    wr_t exp_q[$];

    // Capture every write strobe seen mid-cycle
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) got_q.push_back('{addr: bus.mem_addr, data: bus.mem_data});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    function automatic bq_t with_chk(input bq_t f);
        logic [7:0] c = 8'h00;
        foreach (f[i]) c ^= f[i];
        f.push_back(c);
        return f;
    endfunction

    // Walks a frame body (bytes after SYNC) the way the loader must interpret it
    task automatic model_frame(input bq_t f, output int used, output bit good);
        logic [7:0] chk, hi, lo;
        int n, idx;
        chk  = f[0];
        n    = int'(f[0]);
        idx  = 1;
        good = 1'b0;
        if (n > int'(MAXW)) begin
            used = 1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            hi  = f[idx];
            chk ^= hi;
            if (hi > 8'h0F) begin
                used = idx + 1;
                return;
            end
            lo  = f[idx+1];
            chk ^= lo;
            exp_q.push_back('{addr: 12'(w), data: {hi[3:0], lo}});
            idx += 2;
        end
        good = (f[idx] == chk);
        used = idx + 1;
    endtask

    task automatic check_writes(input string tag);
        int m;
        check({tag, ".nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s.addr%0d", tag, i), 32'(got_q[i].addr), 32'(exp_q[i].addr));
            check($sformatf("%s.data%0d", tag, i), 32'(got_q[i].data), 32'(exp_q[i].data));
        end
    endtask

    task automatic check_status(input string tag, input bit hold, input bit done, input bit err);
        check({tag, ".core_hold"}, 32'(core_hold), 32'(hold));
        check({tag, ".load_done"}, 32'(load_done), 32'(done));
        check({tag, ".load_error"}, 32'(load_error), 32'(err));
    endtask

    task automatic run_frame(input string tag, input bq_t f);
        int used;
        bit good;
        got_q.delete();
        exp_q.delete();
        model_frame(f, used, good);
        send_byte(8'hA5, 1);
        check_status({tag, ".in_frame"}, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < used; i++) send_byte(f[i], $urandom_range(1, 3));
        repeat (3) @(negedge clk);
        check_writes(tag);
        check_status(tag, !good, good, !good);
    endtask

    function automatic bq_t gen_frame();
        bq_t f;
        logic [7:0] hi, lo;
        int n;
        int r = $urandom_range(0, 9);
        n = (r == 0) ? int'(MAXW) : (r == 1) ? int'(MAXW) + 1 : $urandom_range(0, 5);
        f.push_back(8'(n));
        for (int w = 0; w < n; w++) begin
            hi = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) hi[4] = 1'b1;
            lo = 8'($urandom);
            f.push_back(hi);
            f.push_back(lo);
        end
        f = with_chk(f);
        if ($urandom_range(0, 4) == 0) f[f.size()-1] ^= 8'(1 << $urandom_range(0, 7));
        return f;
    endfunction

    initial begin
        bq_t f;
        reset_n      = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst.mem_addr", 32'(bus.mem_addr), 32'h0);
        check("rst.mem_data", 32'(bus.mem_data), 32'h0);
        check("rst.mem_we", 32'(bus.mem_we), 32'h0);
        check_status("rst", 1'b1, 1'b0, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two-word frame with correct checksum
        f = with_chk('{8'h02, 8'h01, 8'h23, 8'h0F, 8'hFF});
        check("t1.chk_value", 32'(f[5]), 32'hD0);
        run_frame("t1", f);
        if (got_q.size() == 2) begin
            check("t1.word0", 32'(got_q[0].data), 32'h123);
            check("t1.word1", 32'(got_q[1].data), 32'hFFF);
        end

        // Empty frame
        run_frame("t2", '{8'h00, 8'h00});

        // Bad checksum after both writes, then recovery
        run_frame("t3", '{8'h02, 8'h01, 8'h23, 8'h0F, 8'hFF, 8'hD3});
        run_frame("t3r", with_chk('{8'h02, 8'h01, 8'h23, 8'h0F, 8'hFF}));

        // HI nibble error
        run_frame("t4", '{8'h01, 8'h12});

        // SYNC value as data, N at the maximum and one past it
        run_frame("sync_data", with_chk('{8'h01, 8'h0A, 8'hA5}));
        f = '{8'(MAXW)};
        for (int i = 0; i < int'(MAXW); i++) begin
            f.push_back(8'(i & 15));
            f.push_back(8'(i * 7));
        end
        run_frame("n_max", with_chk(f));
        run_frame("n_over", with_chk('{8'(MAXW + 1)}));

        // Inter-byte timeout
        got_q.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        repeat (TMO - 6) @(negedge clk);
        check_status("t5.before", 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check_status("t5.after", 1'b1, 1'b0, 1'b1);
        check("t5.nwr", 32'(got_q.size()), 32'h0);

        // Recover, then reset mid-frame after the first write
        run_frame("pre6", with_chk('{8'h01, 8'h03, 8'h44}));
        got_q.delete();
        send_byte(8'hA5, 1);
        send_byte(8'h02, 1);
        send_byte(8'h05, 1);
        send_byte(8'h67, 2);
        check("t6.nwr", 32'(got_q.size()), 32'h1);
        check("t6.core_hold_pre", 32'(core_hold), 32'h1);
        check("t6.data_pre", 32'(bus.mem_data), 32'h567);
        #2 reset_n = 1'b0;
        #1;
        check("t6.mem_addr", 32'(bus.mem_addr), 32'h0);
        check("t6.mem_data", 32'(bus.mem_data), 32'h0);
        check("t6.mem_we", 32'(bus.mem_we), 32'h0);
        check_status("t6.rst", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        got_q.delete();
        send_byte(8'h11, 1);
        send_byte(8'h22, 3);
        check_status("t6.noise", 1'b1, 1'b0, 1'b0);
        check("t6.noise_nwr", 32'(got_q.size()), 32'h0);
        run_frame("t6.after", with_chk('{8'h02, 8'h0C, 8'h01, 8'h00, 8'hA5}));

        // Random frames
        for (int k = 0; k < 30; k++) run_frame($sformatf("rnd%0d", k), gen_frame());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
